// File: rtl/iir_pkg.sv
// Shared types and constants for the IIR datapath multiplier.
package iir_pkg;
  localparam int WIDTH  = 8;
  localparam int PWIDTH = 16;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_e;

  // -128 maps to 8'h80, which is correct as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs8(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 8'd1) : x;
  endfunction
endpackage

// File: rtl/FA_8bit.sv
// 8-bit ripple-carry adder built from a chain of full-adder cells.
module FA_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] s_o,
  output logic       c_o
);
  logic [8:0] c;

  assign c[0] = c_i;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign c_o = c[8];
endmodule

// File: rtl/iir_shift_add_mult.sv
// Sequential signed 8x8 shift-add multiplier: magnitude product over 8 MUL
// cycles through one 8-bit adder, then a sign fix-up cycle.
module iir_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p_out,
  output logic                 busy
);
  import iir_pkg::*;

  if (WIDTH != 8) begin : g_width_chk
    $error("iir_shift_add_mult supports only WIDTH=8");
  end

  state_e             state_q, state_d;
  logic [7:0]         mcand_q, mcand_d;
  logic [7:0]         mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [7:0]         acc_hi_q, acc_hi_d;
  logic [7:0]         acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PWIDTH-1:0]  p_q, p_d;

  logic [7:0]         pp;
  logic [7:0]         sum;
  logic               sum_c;
  logic [PWIDTH-1:0]  mag;

  assign pp = mplier_q[0] ? mcand_q : 8'd0;

  FA_8bit u_fa (
    .a_i (acc_hi_q),
    .b_i (pp),
    .c_i (1'b0),
    .s_o (sum),
    .c_o (sum_c)
  );

  assign mag = {acc_hi_q, acc_lo_q};

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        mcand_d  = abs8(a_in);
        mplier_d = abs8(b_in);
        neg_d    = a_in[7] ^ b_in[7];
        acc_hi_d = '0;
        acc_lo_d = '0;
        cnt_d    = '0;
        state_d  = MUL;
      end
      MUL: begin
        // {c, s, acc_lo} >> 1, the shifted-out lsb is a finished product bit
        acc_hi_d = {sum_c, sum[7:1]};
        acc_lo_d = {sum[0], acc_lo_q[7:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(7)) state_d = SIGN;
      end
      SIGN: begin
        p_d     = neg_q ? (~mag + 16'd1) : mag;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign p_out     = p_q;
endmodule
